conv1_pool: RTL and testbench

CONV1_POOL -- requirements
Module: conv1_pool

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pool2x2_ch.sv | 65 ++++++
 rtl/conv1_pool.sv | 106 ++++++++++
 tb/tb_conv1_pool.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants: conv sample width, conv1 map size and channel count.
// Parameter defaults of the conv1 pooling stage are taken from here.
package cnn_pkg;

    localparam int DATA_W      = 12;
    localparam int CONV1_MAP_W = 24;
    localparam int CONV1_CH    = 3;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool2x2_ch.sv
// One channel of 2x2 stride-2 max pooling: optional ReLU, pair register,
// half-width line buffer and window compare. ReLU enabled by CONV1_POOL_RELU_EN.
module pool2x2_ch
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IN_W   = cnn_pkg::CONV1_MAP_W,
    localparam int HALF_W = IN_W / 2,
    localparam int IDX_W  = idx_w(HALF_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_col_odd,
    input  logic                     i_row_odd,
    input  logic [IDX_W-1:0]         i_lb_idx,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic signed [DATA_W-1:0] o_pool
);

    logic signed [DATA_W-1:0] w_sample;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W-1:0] w_lb_rd;
    logic signed [DATA_W-1:0] w_win_max;
    logic signed [DATA_W-1:0] r_pair;
    logic signed [DATA_W-1:0] r_pool;
    logic signed [DATA_W-1:0] r_lb [HALF_W];

`ifdef CONV1_POOL_RELU_EN
    assign w_sample = i_sample[DATA_W-1] ? '0 : i_sample;
`else
    assign w_sample = i_sample;
`endif

    // All operands are signed and equal width, so these are true signed compares.
    assign w_pair_max = (w_sample > r_pair) ? w_sample : r_pair;
    assign w_lb_rd    = r_lb[i_lb_idx];
    assign w_win_max  = (w_lb_rd > w_pair_max) ? w_lb_rd : w_pair_max;

    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair <= '0;
            r_pool <= '0;
        end else if (i_valid) begin
            if (!i_col_odd) begin
                r_pair <= w_sample;
            end else if (i_row_odd) begin
                r_pool <= w_win_max;
            end
        end
    end

    // NOTE: the line buffer has no reset; an even row always writes entry col/2
    // before the following odd row reads it, and a reset restarts at row 0.
    always_ff @(posedge clk) begin
        if (i_valid && i_col_odd && !i_row_odd) begin
            r_lb[i_lb_idx] <= w_pair_max;
        end
    end

    assign o_pool = r_pool;

endmodule

// File: rtl/conv1_pool.sv
// Conv1 2x2 max pooling over three channels with shared raster counters and
// valid/frame_done control. Define CONV1_POOL_RELU_EN to ReLU inputs before pooling.
module conv1_pool
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IN_W   = cnn_pkg::CONV1_MAP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_out_calc,
    input  logic signed [DATA_W-1:0] conv_out_1,
    input  logic signed [DATA_W-1:0] conv_out_2,
    input  logic signed [DATA_W-1:0] conv_out_3,
    output logic signed [DATA_W-1:0] pool_out_1,
    output logic signed [DATA_W-1:0] pool_out_2,
    output logic signed [DATA_W-1:0] pool_out_3,
    output logic                     valid_out_pool,
    output logic                     frame_done
);

    localparam int CNT_W  = idx_w(IN_W);
    localparam int HALF_W = IN_W / 2;
    localparam int IDX_W  = idx_w(HALF_W);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] w_col_nxt;
    logic [CNT_W-1:0] w_row_nxt;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_win_done;
    logic [IDX_W-1:0] w_lb_idx;
    logic             r_valid_pool;
    logic             r_frame_done;

    assign w_last_col = (r_col == CNT_W'(IN_W - 1));
    assign w_last_row = (r_row == CNT_W'(IN_W - 1));
    assign w_win_done = valid_out_calc && r_col[0] && r_row[0];
    assign w_lb_idx   = IDX_W'(r_col >> 1);

    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (valid_out_calc) begin
            if (w_last_col) begin
                w_col_nxt = '0;
                w_row_nxt = w_last_row ? '0 : r_row + CNT_W'(1);
            end else begin
                w_col_nxt = r_col + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_valid_pool <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_valid_pool <= w_win_done;
            r_frame_done <= w_win_done && w_last_col && w_last_row;
        end
    end

    pool2x2_ch #(.DATA_W(DATA_W), .IN_W(IN_W)) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (valid_out_calc),
        .i_col_odd (r_col[0]),
        .i_row_odd (r_row[0]),
        .i_lb_idx  (w_lb_idx),
        .i_sample  (conv_out_1),
        .o_pool    (pool_out_1)
    );

    pool2x2_ch #(.DATA_W(DATA_W), .IN_W(IN_W)) u_ch2 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (valid_out_calc),
        .i_col_odd (r_col[0]),
        .i_row_odd (r_row[0]),
        .i_lb_idx  (w_lb_idx),
        .i_sample  (conv_out_2),
        .o_pool    (pool_out_2)
    );

    pool2x2_ch #(.DATA_W(DATA_W), .IN_W(IN_W)) u_ch3 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (valid_out_calc),
        .i_col_odd (r_col[0]),
        .i_row_odd (r_row[0]),
        .i_lb_idx  (w_lb_idx),
        .i_sample  (conv_out_3),
        .o_pool    (pool_out_3)
    );

    assign valid_out_pool = r_valid_pool;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_conv1_pool.sv
// Directed bench for conv1_pool: ramp maps, gapped valid, mid-map reset and
// back-to-back maps; expectations adapt to CONV1_POOL_RELU_EN.
module tb_conv1_pool;

    localparam int W  = 24;
    localparam int PW = W / 2;
    localparam int NP = PW * PW;

    logic clk = 1'b0;
    logic rst;
    logic valid_out_calc;
    logic signed [11:0] conv_out_1, conv_out_2, conv_out_3;
    logic signed [11:0] pool_out_1, pool_out_2, pool_out_3;
    logic valid_out_pool, frame_done;

    typedef struct packed {
        logic [35:0] v;
        logic        fd;
        logic [31:0] cyc;
    } pulse_t;

    pulse_t q[$];
    int     exp_cyc[$];
    int     cyc = 0;
    int     stray_fd = 0;
    int     n_vec = 0;
    int     n_err = 0;

    conv1_pool #(.DATA_W(12), .IN_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_out_calc (valid_out_calc),
        .conv_out_1     (conv_out_1),
        .conv_out_2     (conv_out_2),
        .conv_out_3     (conv_out_3),
        .pool_out_1     (pool_out_1),
        .pool_out_2     (pool_out_2),
        .pool_out_3     (pool_out_3),
        .valid_out_pool (valid_out_pool),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out_pool)
            q.push_back('{v: {pool_out_3, pool_out_2, pool_out_1}, fd: frame_done, cyc: cyc});
        else if (frame_done)
            stray_fd++;
    end

    // Stimulus maps: m=0 rising ramp on ch1, m=1 falling ramp; ch3 top-left of
    // map 0 carries the extreme-value window.
    function automatic logic signed [11:0] px(input int m, input int ch, input int r, input int c);
        if (ch == 1)
            return (m == 0) ? 12'(r * W + c) : 12'(575 - (r * W + c));
        if (ch == 2)
            return (m == 0) ? -12'sd5 : 12'(r - c);
        if (m == 0 && r == 0 && c == 0) return -12'sd2048;
        if (m == 0 && r == 0 && c == 1) return 12'sd2047;
        if (m == 0 && r == 1 && c == 0) return 12'sd0;
        if (m == 0 && r == 1 && c == 1) return -12'sd1;
        return 12'((c * 37 + r * 53 + m * 11) % 256 - 128);
    endfunction

    function automatic logic signed [11:0] relu(input logic signed [11:0] x);
`ifdef CONV1_POOL_RELU_EN
        return (x < 0) ? 12'sd0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic signed [11:0] exp_pool(input int m, input int ch, input int pr, input int pc);
        logic signed [11:0] best, s;
        best = relu(px(m, ch, 2 * pr, 2 * pc));
        for (int k = 1; k < 4; k++) begin
            s = relu(px(m, ch, 2 * pr + k / 2, 2 * pc + k % 2));
            if (s > best) best = s;
        end
        return best;
    endfunction

    task automatic clear_q();
        q.delete();
        exp_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_out_calc = 1'b0;
        end
    endtask

    // Leaves valid high on the last pixel so a following map starts with no gap.
    task automatic drive_map(input int m, input int max_gap, input int npix);
        int r, c, gap;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(negedge clk);
                valid_out_calc = 1'b0;
                conv_out_1 = 12'($urandom);
                conv_out_2 = 12'($urandom);
                conv_out_3 = 12'($urandom);
            end
            @(negedge clk);
            valid_out_calc = 1'b1;
            conv_out_1 = px(m, 1, r, c);
            conv_out_2 = px(m, 2, r, c);
            conv_out_3 = px(m, 3, r, c);
            if ((r % 2 == 1) && (c % 2 == 1)) exp_cyc.push_back(cyc + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_out_calc = 1'b0;
        conv_out_1 = '0;
        conv_out_2 = '0;
        conv_out_3 = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (pool_out_1 !== 12'sd0) begin n_err++; $display("FAIL reset pool_out_1: got %0d want 0", pool_out_1); end
        n_vec++; if (pool_out_2 !== 12'sd0) begin n_err++; $display("FAIL reset pool_out_2: got %0d want 0", pool_out_2); end
        n_vec++; if (pool_out_3 !== 12'sd0) begin n_err++; $display("FAIL reset pool_out_3: got %0d want 0", pool_out_3); end
        n_vec++; if (valid_out_pool !== 1'b0) begin n_err++; $display("FAIL reset valid_out_pool: got %b want 0", valid_out_pool); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        logic signed [11:0] got, want;
        clear_q();
        drive_map(0, 0, W * W);
        idle(4);
        n_vec++;
        if (q.size() != NP) begin
            n_err++; $display("FAIL ramp pulse count: got %0d want %0d", q.size(), NP);
        end else begin
            for (int i = 0; i < NP; i++) begin
                for (int ch = 1; ch <= 3; ch++) begin
                    got  = $signed(q[i].v[(ch-1)*12 +: 12]);
                    want = exp_pool(0, ch, i / PW, i % PW);
                    n_vec++; if (got !== want) begin n_err++; $display("FAIL ramp out%0d ch%0d: got %0d want %0d", i, ch, got, want); end
                end
                n_vec++; if (q[i].fd !== 1'(i == NP - 1)) begin n_err++; $display("FAIL ramp frame_done out%0d: got %b", i, q[i].fd); end
                n_vec++; if (q[i].cyc !== 32'(exp_cyc[i])) begin n_err++; $display("FAIL ramp latency out%0d: got cycle %0d want %0d", i, q[i].cyc, exp_cyc[i]); end
            end
            n_vec++; if ($signed(q[0].v[11:0]) !== 12'sd25) begin n_err++; $display("FAIL ramp first ch1: got %0d want 25", $signed(q[0].v[11:0])); end
            n_vec++; if ($signed(q[NP-1].v[11:0]) !== 12'sd575) begin n_err++; $display("FAIL ramp last ch1: got %0d want 575", $signed(q[NP-1].v[11:0])); end
            n_vec++; if ($signed(q[0].v[35:24]) !== 12'sd2047) begin n_err++; $display("FAIL window ch3: got %0d want 2047", $signed(q[0].v[35:24])); end
`ifdef CONV1_POOL_RELU_EN
            n_vec++; if ($signed(q[0].v[23:12]) !== 12'sd0) begin n_err++; $display("FAIL const ch2: got %0d want 0", $signed(q[0].v[23:12])); end
`else
            n_vec++; if ($signed(q[0].v[23:12]) !== -12'sd5) begin n_err++; $display("FAIL const ch2: got %0d want -5", $signed(q[0].v[23:12])); end
`endif
        end
    endtask

    task automatic test_gaps();
        logic signed [11:0] got, want;
        clear_q();
        drive_map(0, 3, W * W);
        idle(4);
        n_vec++;
        if (q.size() != NP) begin
            n_err++; $display("FAIL gaps pulse count: got %0d want %0d", q.size(), NP);
        end else begin
            for (int i = 0; i < NP; i++) begin
                for (int ch = 1; ch <= 3; ch++) begin
                    got  = $signed(q[i].v[(ch-1)*12 +: 12]);
                    want = exp_pool(0, ch, i / PW, i % PW);
                    n_vec++; if (got !== want) begin n_err++; $display("FAIL gaps out%0d ch%0d: got %0d want %0d", i, ch, got, want); end
                end
                n_vec++; if (q[i].fd !== 1'(i == NP - 1)) begin n_err++; $display("FAIL gaps frame_done out%0d: got %b", i, q[i].fd); end
                n_vec++; if (q[i].cyc !== 32'(exp_cyc[i])) begin n_err++; $display("FAIL gaps latency out%0d: got cycle %0d want %0d", i, q[i].cyc, exp_cyc[i]); end
            end
        end
    endtask

    task automatic test_reset_midmap();
        logic signed [11:0] got, want;
        clear_q();
        drive_map(0, 0, 300);
        @(negedge clk);
        valid_out_calc = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (pool_out_1 !== 12'sd0) begin n_err++; $display("FAIL midrst pool_out_1: got %0d want 0", pool_out_1); end
        n_vec++; if (pool_out_2 !== 12'sd0) begin n_err++; $display("FAIL midrst pool_out_2: got %0d want 0", pool_out_2); end
        n_vec++; if (pool_out_3 !== 12'sd0) begin n_err++; $display("FAIL midrst pool_out_3: got %0d want 0", pool_out_3); end
        n_vec++; if (valid_out_pool !== 1'b0) begin n_err++; $display("FAIL midrst valid_out_pool: got %b want 0", valid_out_pool); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
        drive_map(0, 0, W * W);
        idle(4);
        n_vec++;
        if (q.size() != NP) begin
            n_err++; $display("FAIL midrst pulse count: got %0d want %0d", q.size(), NP);
        end else begin
            for (int i = 0; i < NP; i++) begin
                for (int ch = 1; ch <= 3; ch++) begin
                    got  = $signed(q[i].v[(ch-1)*12 +: 12]);
                    want = exp_pool(0, ch, i / PW, i % PW);
                    n_vec++; if (got !== want) begin n_err++; $display("FAIL midrst out%0d ch%0d: got %0d want %0d", i, ch, got, want); end
                end
                n_vec++; if (q[i].fd !== 1'(i == NP - 1)) begin n_err++; $display("FAIL midrst frame_done out%0d: got %b", i, q[i].fd); end
                n_vec++; if (q[i].cyc !== 32'(exp_cyc[i])) begin n_err++; $display("FAIL midrst latency out%0d: got cycle %0d want %0d", i, q[i].cyc, exp_cyc[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [11:0] got, want;
        int n_fd;
        clear_q();
        drive_map(0, 0, W * W);
        drive_map(1, 0, W * W);
        idle(4);
        n_vec++;
        if (q.size() != 2 * NP) begin
            n_err++; $display("FAIL b2b pulse count: got %0d want %0d", q.size(), 2 * NP);
        end else begin
            n_fd = 0;
            for (int i = 0; i < 2 * NP; i++) begin
                for (int ch = 1; ch <= 3; ch++) begin
                    got  = $signed(q[i].v[(ch-1)*12 +: 12]);
                    want = exp_pool(i / NP, ch, (i % NP) / PW, i % PW);
                    n_vec++; if (got !== want) begin n_err++; $display("FAIL b2b out%0d ch%0d: got %0d want %0d", i, ch, got, want); end
                end
                n_vec++; if (q[i].fd !== 1'(i % NP == NP - 1)) begin n_err++; $display("FAIL b2b frame_done out%0d: got %b", i, q[i].fd); end
                n_vec++; if (q[i].cyc !== 32'(exp_cyc[i])) begin n_err++; $display("FAIL b2b latency out%0d: got cycle %0d want %0d", i, q[i].cyc, exp_cyc[i]); end
                if (q[i].fd) n_fd++;
            end
            n_vec++; if (n_fd != 2) begin n_err++; $display("FAIL b2b frame_done count: got %0d want 2", n_fd); end
        end
        n_vec++; if (stray_fd != 0) begin n_err++; $display("FAIL frame_done without valid: got %0d want 0", stray_fd); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_reset_midmap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
